// File: rtl/capture_pkg.sv
// Shared constants for the capture RAM read side: ring geometry, scheduler
// state encoding and read-owner tags.
package capture_pkg;

  localparam int CAP_AW       = 14;
  localparam int CAP_DEPTH    = 1 << CAP_AW;
  localparam int CAP_PRE_TRIG = 8192;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SERVE = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  localparam logic OWN_LCD  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop level synchronizer for slow control levels crossing into clk.
module cdc_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/capture_read_sched.sv
// Read-port scheduler for the A/B capture RAMs: LCD/host arbitration,
// trigger-relative address translation and the frame_ready/frame_done handshake.
//
// state | meaning
// IDLE  | waiting for a stored frame
// LATCH | one cycle: capture ring base, clear session flags
// SERVE | arbitrating reads for the current frame
// DONE  | frame_done raised, waiting for frame_ready to drop
module capture_read_sched
  import capture_pkg::*;
#(
  parameter int AW         = CAP_AW,
  parameter int PRE_TRIG   = CAP_PRE_TRIG,
  parameter int RD_LAT     = 2,
  parameter int STARVE_LIM = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_ready,
  input  logic [AW-1:0] trig_pos,
  output logic          frame_done,
  input  logic          lcd_req,
  input  logic [AW-1:0] lcd_idx,
  output logic          lcd_gnt,
  input  logic          host_req,
  input  logic [AW-1:0] host_idx,
  output logic          host_gnt,
  input  logic          lcd_finish,
  input  logic          host_hold,
  output logic          ram_ce,
  output logic [AW-1:0] ram_addr,
  input  logic [7:0]    ram_dout_a,
  input  logic [7:0]    ram_dout_b,
  output logic [7:0]    rdata_a,
  output logic [7:0]    rdata_b,
  output logic          lcd_rvalid,
  output logic          host_rvalid,
  output logic          session_active
);

  localparam int PIPE_D = RD_LAT + 1;
  localparam int SW     = $clog2(STARVE_LIM + 1);
  localparam logic [AW-1:0] PRE_OFS    = AW'(PRE_TRIG);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  sched_state_e      state_q, state_d;
  logic [AW-1:0]     base_q, base_d;
  logic              fin_seen_q, fin_seen_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              session_active_q, session_active_d;
  logic              frame_done_q, frame_done_d;
  logic              ram_ce_q, ram_ce_d;
  logic [AW-1:0]     ram_addr_q, ram_addr_d;
  logic [PIPE_D-1:0] pipe_v_q, pipe_v_d;
  logic [PIPE_D-1:0] pipe_own_q, pipe_own_d;
  logic              lcd_rvalid_q, lcd_rvalid_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [7:0]        rdata_a_q, rdata_a_d;
  logic [7:0]        rdata_b_q, rdata_b_d;

  logic          ready_s;
  logic          serving;
  logic          host_first;
  logic          lcd_win;
  logic          host_win;
  logic          any_win;
  logic          in_flight;
  logic [AW-1:0] sel_idx;
  logic          ret_v;

  cdc_sync2 u_ready_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (frame_ready),
    .q     (ready_s)
  );

  // Grants are withheld as soon as the synchronized ready drops, ahead of the FSM exit.
  assign serving    = (state_q == ST_SERVE) && ready_s;
  assign host_first = host_req && (starve_q == STARVE_MAX);
  assign lcd_win    = serving && lcd_req && !host_first;
  assign host_win   = serving && host_req && !lcd_win;
  assign any_win    = lcd_win || host_win;
  assign sel_idx    = lcd_win ? lcd_idx : host_idx;
  assign in_flight  = any_win || (|pipe_v_q);
  assign ret_v      = pipe_v_q[PIPE_D-1];

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    fin_seen_d = fin_seen_q;
    starve_d   = starve_q;

    case (state_q)
      ST_IDLE: begin
        if (ready_s) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        base_d     = trig_pos - PRE_OFS;
        fin_seen_d = 1'b0;
        starve_d   = '0;
        state_d    = ST_SERVE;
      end
      ST_SERVE: begin
        if (!ready_s) begin
          state_d = ST_IDLE;
        end else begin
          if (lcd_finish) fin_seen_d = 1'b1;
          if (fin_seen_q && !host_hold && !in_flight) state_d = ST_DONE;
          if (!host_req || host_win) starve_d = '0;
          else if (lcd_win)          starve_d = starve_q + SW'(1);
        end
      end
      ST_DONE: begin
        if (!ready_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    session_active_d = (state_d == ST_SERVE);
    frame_done_d     = (state_d == ST_DONE);

    ram_ce_d   = any_win;
    ram_addr_d = any_win ? (base_q + sel_idx) : ram_addr_q;

    // Owner tags keep shifting regardless of state so aborted reads still return.
    pipe_v_d   = {pipe_v_q[PIPE_D-2:0], any_win};
    pipe_own_d = {pipe_own_q[PIPE_D-2:0], (host_win ? OWN_HOST : OWN_LCD)};

    lcd_rvalid_d  = ret_v && (pipe_own_q[PIPE_D-1] == OWN_LCD);
    host_rvalid_d = ret_v && (pipe_own_q[PIPE_D-1] == OWN_HOST);
    rdata_a_d     = ret_v ? ram_dout_a : rdata_a_q;
    rdata_b_d     = ret_v ? ram_dout_b : rdata_b_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      base_q           <= '0;
      fin_seen_q       <= 1'b0;
      starve_q         <= '0;
      session_active_q <= 1'b0;
      frame_done_q     <= 1'b0;
      ram_ce_q         <= 1'b0;
      ram_addr_q       <= '0;
      pipe_v_q         <= '0;
      pipe_own_q       <= '0;
      lcd_rvalid_q     <= 1'b0;
      host_rvalid_q    <= 1'b0;
      rdata_a_q        <= '0;
      rdata_b_q        <= '0;
    end else begin
      state_q          <= state_d;
      base_q           <= base_d;
      fin_seen_q       <= fin_seen_d;
      starve_q         <= starve_d;
      session_active_q <= session_active_d;
      frame_done_q     <= frame_done_d;
      ram_ce_q         <= ram_ce_d;
      ram_addr_q       <= ram_addr_d;
      pipe_v_q         <= pipe_v_d;
      pipe_own_q       <= pipe_own_d;
      lcd_rvalid_q     <= lcd_rvalid_d;
      host_rvalid_q    <= host_rvalid_d;
      rdata_a_q        <= rdata_a_d;
      rdata_b_q        <= rdata_b_d;
    end
  end

  assign lcd_gnt        = lcd_win;
  assign host_gnt       = host_win;
  assign frame_done     = frame_done_q;
  assign session_active = session_active_q;
  assign ram_ce         = ram_ce_q;
  assign ram_addr       = ram_addr_q;
  assign lcd_rvalid     = lcd_rvalid_q;
  assign host_rvalid    = host_rvalid_q;
  assign rdata_a        = rdata_a_q;
  assign rdata_b        = rdata_b_q;

endmodule
